// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: PC, req/gnt/rvalid imem port,
// credit-limited IF/ID buffer and redirect flush with response drop.
module fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        decode_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   r_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [31:0]   r_data [FIFO_DEPTH];
  logic [31:0]   r_pcs  [FIFO_DEPTH];

  logic [CW-1:0] w_live;
  logic          w_credit;
  logic          w_slot;
  logic          w_grant;
  logic          w_drop_rsp;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [31:0]   w_tgt;
  logic [CW-1:0] w_out_nxt;

  // Live requests plus buffered words never exceed the buffer size,
  // so every accepted response has a slot waiting for it.
  assign w_live    = r_out - r_drop;
  assign w_credit  = (w_live + r_cnt) < CW'(FIFO_DEPTH);
  assign w_slot    = r_out < CW'(MAX_OUTSTANDING);
  assign imem_req  = reset_n & w_credit & w_slot;
  assign imem_addr = r_pc;

  assign w_grant    = imem_req & imem_gnt;
  assign w_drop_rsp = imem_rvalid & (r_drop != '0);
  assign w_empty    = (r_cnt == '0);
  assign w_push     = imem_rvalid & ~w_drop_rsp
                    & ~redirect_valid;
  assign w_pop      = ~w_empty & decode_ready
                    & ~redirect_valid;
  assign w_tgt      = redirect_pc & ~32'h3;
  assign w_out_nxt  = r_out + CW'(w_grant)
                    - CW'(imem_rvalid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
      r_out     <= '0;
      r_drop    <= '0;
    end else begin
      r_out <= w_out_nxt;
      unique case (1'b1)
        redirect_valid: begin
          r_pc      <= w_tgt;
          r_resp_pc <= w_tgt;
          r_drop    <= w_out_nxt;
        end
        default: begin
          if (w_grant)
            r_pc <= r_pc + 32'd4;
          if (w_drop_rsp)
            r_drop <= r_drop - CW'(1);
          else if (imem_rvalid)
            r_resp_pc <= r_resp_pc + 32'd4;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
    end else if (redirect_valid) begin
      r_cnt <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + AW'(1);
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: reads are masked by the empty flag.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wr] <= imem_rdata;
      r_pcs[r_wr]  <= r_resp_pc;
    end
  end

  assign instr_valid = ~w_empty;
  assign instruction = w_empty ? NOP : r_data[r_rd];
  assign instr_pc    = w_empty ? 32'h0 : r_pcs[r_rd];

endmodule
